// File: rtl/jt900h_memsrv_pkg.sv
// Shared definitions for the JT900H RAM-port responder: state encoding,
// the registered memory request and a byte-merge helper.
package jt900h_memsrv_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } memsrv_st_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        be;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [1:0]        be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    if (be[0]) res[7:0]  = new_w[7:0];
    if (be[1]) res[15:8] = new_w[15:8];
    return res;
  endfunction

endpackage

// File: rtl/jt900h_cendiv.sv
// Clock-enable divider: counts 0..CEN_DIV-1 and parks on the last value
// while the owner asks to hold, so the next pulse waits for it.
module jt900h_cendiv
  import jt900h_memsrv_pkg::*;
#(
  parameter int CEN_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic pulse_ok
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CEN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_TOP) begin
      cnt_d = hold ? cnt_q : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse_ok = (cnt_q == CNT_TOP);

endmodule

// File: rtl/jt900h_memsrv.sv
// Serves JT900H word reads and byte-masked writes from a req/ack memory,
// stalling the CPU through cpu_cen; a one-word latch absorbs repeated reads.
module jt900h_memsrv
  import jt900h_memsrv_pkg::*;
#(
  parameter int CEN_DIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                cpu_cen,
  input  logic [23:0]         cpu_addr,
  input  logic [DATA_W-1:0]   cpu_din,
  input  logic [1:0]          cpu_we,
  output logic [DATA_W-1:0]   cpu_dout,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [1:0]          mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  if (CEN_DIV < 2 || CEN_DIV > 16) begin : g_bad_div
    $error("jt900h_memsrv: CEN_DIV must be within 2..16");
  end

  memsrv_st_e        st_q, st_d;
  mem_req_t          req_q, req_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              valid_q, valid_d;
  logic              served_q, served_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;

  logic [ADDR_W-1:0] req_addr;
  logic              addr_lsb_unused;
  logic              miss;
  logic              need;
  logic              busy;
  logic              pulse_ok;

  assign req_addr        = cpu_addr[23:1];
  assign addr_lsb_unused = cpu_addr[0];

  assign miss = !valid_q || (req_addr != tag_q);
  assign need = !served_q && ((cpu_we != 2'b00) || miss);
  assign busy = (st_q != ST_IDLE) || need;

  jt900h_cendiv #(
    .CEN_DIV (CEN_DIV)
  ) u_cendiv (
    .clk      (clk),
    .rst      (rst),
    .hold     (busy),
    .pulse_ok (pulse_ok)
  );

  assign cpu_cen = pulse_ok && (st_q == ST_IDLE) && !need;

  always_comb begin
    st_d       = st_q;
    req_d      = req_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    served_d   = served_q;
    cpu_dout_d = cpu_dout_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;

    case (st_q)
      ST_IDLE: begin
        if (need) begin
          req_d.addr = req_addr;
          if (cpu_we != 2'b00) begin
            st_d        = ST_WR;
            req_d.be    = cpu_we;
            req_d.wdata = cpu_din;
            mem_wr_d    = 1'b1;
          end else begin
            st_d     = ST_RD;
            mem_rd_d = 1'b1;
          end
        end else begin
          served_d = 1'b1;
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          cpu_dout_d = mem_rdata;
          tag_d      = req_q.addr;
          valid_d    = 1'b1;
          served_d   = 1'b1;
          mem_rd_d   = 1'b0;
          st_d       = ST_IDLE;
        end
      end
      ST_WR: begin
        if (mem_ack) begin
          // Keep the read latch coherent with what memory now holds.
          if (valid_q && (tag_q == req_q.addr)) begin
            cpu_dout_d = merge_bytes(cpu_dout_q, req_q.wdata, req_q.be);
          end
          served_d = 1'b1;
          mem_wr_d = 1'b0;
          st_d     = ST_IDLE;
        end
      end
      default: begin
        st_d     = ST_IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase

    // The cpu_cen pulse closes the access, so the next one starts unserved.
    if (cpu_cen) begin
      served_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= ST_IDLE;
      req_q      <= '0;
      tag_q      <= '0;
      valid_q    <= 1'b0;
      served_q   <= 1'b0;
      cpu_dout_q <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
    end else begin
      st_q       <= st_d;
      req_q      <= req_d;
      tag_q      <= tag_d;
      valid_q    <= valid_d;
      served_q   <= served_d;
      cpu_dout_q <= cpu_dout_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign cpu_dout  = cpu_dout_q;
  assign mem_addr  = req_q.addr;
  assign mem_be    = req_q.be;
  assign mem_wdata = req_q.wdata;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_jt900h_memsrv.sv
// Randomized bench for jt900h_memsrv: a req/ack memory responder plus a
// word-latch reference model predict transactions, read data and cen timing.
`timescale 1ns/1ps
module tb_jt900h_memsrv;

  localparam int DIV = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_cen;
  logic [23:0] cpu_addr = '0;
  logic [15:0] cpu_din = '0;
  logic [1:0]  cpu_we = '0;
  logic [15:0] cpu_dout;
  logic [22:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  jt900h_memsrv #(.CEN_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_cen   (cpu_cen),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_we    (cpu_we),
    .cpu_dout  (cpu_dout),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents: explicit writes, otherwise an address-derived pattern.
  logic [15:0] mem_model [logic [22:0]];

  function automatic logic [15:0] mem_word(input logic [22:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 16'(a * 23'd40503 + 23'd7);
  endfunction

  function automatic logic [15:0] bmerge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
    return {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
  endfunction

  int          rd_cnt = 0, wr_cnt = 0, ack_cnt = 0;
  int          ack_delay = 1;
  int          wait_left = 0;
  logic        pending = 1'b0;
  logic        req_is_wr = 1'b0;
  logic [22:0] last_addr = '0;
  logic [1:0]  last_be = '0;
  logic [15:0] last_wdata = '0;

  // Memory responder: latches each new request, checks it stays stable,
  // and acks ack_delay cycles after first seeing it.
  initial begin
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!rst) begin
        pending = 1'b0;
      end else if (mem_rd || mem_wr) begin
        if (mem_rd && mem_wr) check("rd_wr_exclusive", 32'd1, 32'd0);
        if (!pending) begin
          pending    = 1'b1;
          req_is_wr  = mem_wr;
          last_addr  = mem_addr;
          last_be    = mem_be;
          last_wdata = mem_wdata;
          wait_left  = ack_delay;
          if (mem_wr) wr_cnt++;
          else rd_cnt++;
        end else begin
          check("req_stable", {mem_wr, mem_rd, mem_be, mem_addr},
                {req_is_wr, !req_is_wr, last_be, last_addr});
          if (req_is_wr) check("wdata_stable", mem_wdata, last_wdata);
          wait_left--;
          if (wait_left <= 0) begin
            mem_ack = 1'b1;
            ack_cnt++;
            pending = 1'b0;
            if (req_is_wr) mem_model[last_addr] = bmerge(mem_word(last_addr), last_wdata, last_be);
            else mem_rdata = mem_word(last_addr);
          end
        end
      end
    end
  end

  // Reference read latch.
  logic        ref_valid = 1'b0;
  logic [22:0] ref_tag = '0;
  logic [15:0] ref_data = '0;

  task automatic cpu_access(input logic [23:0] addr, input logic [1:0] we,
                            input logic [15:0] din, input string tag);
    int          rd0, wr0, ak0, cyc, exp_rd, exp_wr;
    logic        hit;
    logic [22:0] w;
    logic [15:0] miss_data;
    rd0 = rd_cnt; wr0 = wr_cnt; ak0 = ack_cnt;
    w = addr[23:1];
    hit = ref_valid && (ref_tag == w);
    miss_data = mem_word(w);
    exp_rd = (we == 2'b00 && !hit) ? 1 : 0;
    exp_wr = (we != 2'b00) ? 1 : 0;
    cpu_addr = addr; cpu_we = we; cpu_din = din;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cpu_cen || cyc >= 300) break;
    end
    if (!cpu_cen) check({tag, "_cen_timeout"}, 32'd0, 32'd1);
    if (we == 2'b00) begin
      if (!hit) begin
        ref_valid = 1'b1; ref_tag = w; ref_data = miss_data;
      end
    end else if (hit) begin
      ref_data = bmerge(ref_data, din, we);
    end
    check({tag, "_rd_txn"}, rd_cnt - rd0, exp_rd);
    check({tag, "_wr_txn"}, wr_cnt - wr0, exp_wr);
    check({tag, "_acks_before_cen"}, ack_cnt - ak0, exp_rd + exp_wr);
    check({tag, "_dout"}, cpu_dout, ref_data);
    if (we == 2'b00 && hit) check({tag, "_hit_period"}, cyc, DIV);
    $display("txn %s addr=%06h we=%b din=%04h dout=%04h cycles=%0d", tag, addr, we, din, cpu_dout, cyc);
    @(posedge clk); #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d8;
    int          wr0, cyc;
    logic [22:0] pool [5];
    pool[0] = 23'h000080; pool[1] = 23'h000081; pool[2] = 23'h000100;
    pool[3] = 23'h7FFFFF; pool[4] = 23'h7FFFFE;
    mem_model[23'h000080] = 16'hBEEF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_cen", cpu_cen, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_cpu_dout", cpu_dout, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b1;

    // Reset then read, then read hit on the odd byte address
    ack_delay = 1;
    cpu_access(24'h000100, 2'b00, 16'h0000, "first_read");
    check("first_read_addr", last_addr, 23'h000080);
    check("first_read_data", cpu_dout, 16'hBEEF);
    cpu_access(24'h000101, 2'b00, 16'h0000, "read_hit");

    // Byte write merging into the latch, then confirm the latch stays valid
    d8 = 16'($urandom_range(0, 255));
    cpu_access(24'h000100, 2'b10, {8'h12, d8[7:0]}, "byte_write");
    check("byte_write_be", last_be, 2'b10);
    check("byte_write_wdata", last_wdata, {8'h12, d8[7:0]});
    check("byte_write_merge", cpu_dout, 16'h12EF);
    cpu_access(24'h000100, 2'b00, 16'h0000, "read_after_write");

    // Slow memory
    ack_delay = 20;
    cpu_access(24'h000400, 2'b00, 16'h0000, "slow_read");
    ack_delay = 1;
    cpu_access(24'h000401, 2'b00, 16'h0000, "slow_read_hit");

    // Reset while a write is outstanding
    cpu_access(24'h000300, 2'b00, 16'h0000, "pre_reset_read");
    ack_delay = 20;
    cpu_addr = 24'h000300; cpu_we = 2'b01; cpu_din = 16'h00A5;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_wr || cyc >= 50) break;
    end
    check("reset_wr_started", mem_wr, 1);
    #2;
    rst = 1'b0;
    #1;
    check("reset_async_wr", mem_wr, 0);
    check("reset_async_rd", mem_rd, 0);
    check("reset_async_cen", cpu_cen, 0);
    ref_valid = 1'b0; ref_data = '0;
    repeat (2) @(posedge clk);
    #1;
    cpu_we = 2'b00;
    rst = 1'b1;
    ack_delay = 1;
    cpu_access(24'h000300, 2'b00, 16'h0000, "post_reset_read");

    // Back-to-back writes to the same word
    wr0 = wr_cnt;
    cpu_access(24'h000200, 2'b11, 16'hC0DE, "b2b_write_a");
    cpu_access(24'h000200, 2'b11, 16'hC0DE, "b2b_write_b");
    check("b2b_write_count", wr_cnt - wr0, 2);
    cpu_access(24'h000200, 2'b00, 16'h0000, "b2b_readback");

    // Random traffic over a small pool of words, including the top word
    for (int i = 0; i < 80; i++) begin
      logic [22:0] w;
      logic [1:0]  we;
      int          r;
      w = pool[$urandom_range(0, 4)];
      r = $urandom_range(0, 5);
      we = (r < 3) ? 2'b00 : 2'(r - 2);
      ack_delay = $urandom_range(1, 4);
      cpu_access({w, 1'($urandom_range(0, 1))}, we, 16'($urandom), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
